// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the ID-stage hazard unit and the forwarding unit.
package hazard_unit_pkg;

    localparam int REG_W_DFLT = 5;

    typedef enum logic [1:0] {
        ADDR_PC4    = 2'b00,
        ADDR_JUMP   = 2'b01,
        ADDR_BRANCH = 2'b10
    } addrSel_e;

    typedef enum logic {
        NO_HAZ    = 1'b0,
        BRANCH_EX = 1'b1
    } hazState_e;

endpackage

// File: rtl/hazard_unit_load_use_detect.sv
// Load-use comparator: flags a load in EX whose destination feeds the ID instruction.
module load_use_detect
    import hazard_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DFLT
) (
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUseShamt,
    input  logic             idUseImmed,
    input  logic             idMemWrite,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRw,
    output logic             loadHaz
);

    logic rsHit;
    logic rtHit;

    // Stores read Rt as data even though they also use an immediate.
    assign rsHit   = (exRw == idRs) && !idUseShamt;
    assign rtHit   = (exRw == idRt) && (!idUseImmed || idMemWrite);
    assign loadHaz = exMemRead && (exRw != '0) && (rsHit || rtHit);

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard/control-flow sequencer: load-use stalls, jump and branch penalties.
// Optional stall counter enabled by defining HAZARD_STALL_COUNT_EN.
//
//   state     | meaning
//   NO_HAZ    | normal flow; load-use, branch in ID and jump in IF evaluated
//   BRANCH_EX | branch resolving in EX, ID holds a nop
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DFLT
`ifdef HAZARD_STALL_COUNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IF_Jump,
    input  logic             ID_Branch,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UseShamt,
    input  logic             ID_UseImmed,
    input  logic             ID_MemWrite,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rw,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic [1:0]       AddrSel,
    output logic             IF_Write,
    output logic             IF_Flush,
    output logic             Bubble
`ifdef HAZARD_STALL_COUNT_EN
    , output logic [CNT_W-1:0] StallCount
`endif
);

    hazState_e state;
    hazState_e nextState;
    logic      loadHaz;

    load_use_detect #(.REG_W(REG_W)) uLoadUse (
        .idRs       (ID_Rs),
        .idRt       (ID_Rt),
        .idUseShamt (ID_UseShamt),
        .idUseImmed (ID_UseImmed),
        .idMemWrite (ID_MemWrite),
        .exMemRead  (EX_MemRead),
        .exRw       (EX_Rw),
        .loadHaz    (loadHaz)
    );

    always_ff @(posedge CLK) begin
        if (Reset) state <= NO_HAZ;
        else       state <= nextState;
    end

    always_comb begin
        nextState = NO_HAZ;
        PC_Write  = 1'b1;
        AddrSel   = ADDR_PC4;
        IF_Write  = 1'b1;
        IF_Flush  = 1'b0;
        Bubble    = 1'b0;
        if (Reset) begin
            IF_Flush = 1'b1;
            Bubble   = 1'b1;
        end else begin
            case (state)
                NO_HAZ: begin
                    if (loadHaz) begin
                        PC_Write = 1'b0;
                        IF_Write = 1'b0;
                        Bubble   = 1'b1;
                    end else if (ID_Branch) begin
                        PC_Write  = 1'b0;
                        IF_Flush  = 1'b1;
                        nextState = BRANCH_EX;
                    end else if (IF_Jump) begin
                        AddrSel  = ADDR_JUMP;
                        IF_Flush = 1'b1;
                    end
                end
                BRANCH_EX: begin
                    // PC still holds branch+4, so a not-taken branch just resumes.
                    if (EX_BranchTaken) begin
                        AddrSel  = ADDR_BRANCH;
                        IF_Flush = 1'b1;
                    end else if (IF_Jump) begin
                        AddrSel  = ADDR_JUMP;
                        IF_Flush = 1'b1;
                    end
                end
                default: nextState = NO_HAZ;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    always_ff @(posedge CLK) begin
        if (Reset)          StallCount <= '0;
        else if (!PC_Write) StallCount <= StallCount + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then randomized traffic
// against a rule-level reference model.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int RW = 5;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          Reset, IF_Jump, ID_Branch, ID_UseShamt, ID_UseImmed, ID_MemWrite;
    logic          EX_MemRead, EX_BranchTaken;
    logic [RW-1:0] ID_Rs, ID_Rt, EX_Rw;
    logic          PC_Write, IF_Write, IF_Flush, Bubble;
    logic [1:0]    AddrSel;
    logic [CW-1:0] StallCount;

    int          numCompared   = 0;
    int          numMismatched = 0;
    bit          modelBranchPending = 1'b0;
    int unsigned modelStalls = 0;

    always #5 CLK = ~CLK;

    hazard_unit dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .IF_Jump        (IF_Jump),
        .ID_Branch      (ID_Branch),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UseShamt    (ID_UseShamt),
        .ID_UseImmed    (ID_UseImmed),
        .ID_MemWrite    (ID_MemWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_Rw          (EX_Rw),
        .EX_BranchTaken (EX_BranchTaken),
        .PC_Write       (PC_Write),
        .AddrSel        (AddrSel),
        .IF_Write       (IF_Write),
        .IF_Flush       (IF_Flush),
        .Bubble         (Bubble)
`ifdef HAZARD_STALL_COUNT_EN
        , .StallCount   (StallCount)
`endif
    );

`ifndef HAZARD_STALL_COUNT_EN
    assign StallCount = '0;
`endif

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit refLoadHaz();
        bit rsRead = !ID_UseShamt;
        bit rtRead = !ID_UseImmed || ID_MemWrite;
        return EX_MemRead && (EX_Rw != 0) &&
               ((rsRead && EX_Rw == ID_Rs) || (rtRead && EX_Rw == ID_Rt));
    endfunction

    // Packed {PC_Write, AddrSel[1:0], IF_Write, IF_Flush, Bubble}
    function automatic logic [5:0] refOut();
        if (Reset)                      return 6'b1_00_1_1_1;
        if (modelBranchPending) begin
            if (EX_BranchTaken)         return 6'b1_10_1_1_0;
            if (IF_Jump)                return 6'b1_01_1_1_0;
            return 6'b1_00_1_0_0;
        end
        if (refLoadHaz())               return 6'b0_00_0_0_1;
        if (ID_Branch)                  return 6'b0_00_1_1_0;
        if (IF_Jump)                    return 6'b1_01_1_1_0;
        return 6'b1_00_1_0_0;
    endfunction

    task automatic drive(input bit rst, input bit jmp, input bit br, input int rs, input int rt,
                         input bit sh, input bit im, input bit mw, input bit mr, input int rw,
                         input bit tk);
        Reset = rst; IF_Jump = jmp; ID_Branch = br;
        ID_Rs = RW'(rs); ID_Rt = RW'(rt);
        ID_UseShamt = sh; ID_UseImmed = im; ID_MemWrite = mw;
        EX_MemRead = mr; EX_Rw = RW'(rw); EX_BranchTaken = tk;
    endtask

    // Sample at negedge against the model (and optionally a literal), then advance the model.
    task automatic cycle(input string tag, input bit useLit, input logic [5:0] lit);
        logic [5:0] exp;
        logic [5:0] obs;
        @(negedge CLK);
        exp = refOut();
        obs = {PC_Write, AddrSel, IF_Write, IF_Flush, Bubble};
        checkVal({tag, "_outs"}, 32'(obs), 32'(exp));
        if (useLit) checkVal({tag, "_lit"}, 32'(obs), 32'(lit));
`ifdef HAZARD_STALL_COUNT_EN
        checkVal({tag, "_cnt"}, 32'(StallCount), modelStalls & 32'hFFFF);
`endif
        @(posedge CLK);
        if (Reset) begin
            modelBranchPending = 1'b0;
            modelStalls = 0;
        end else begin
            if (exp[5] == 1'b0) modelStalls++;
            modelBranchPending = !modelBranchPending && !refLoadHaz() && ID_Branch;
        end
        #1;
    endtask

    localparam logic [5:0] L_RST   = 6'b1_00_1_1_1;
    localparam logic [5:0] L_IDLE  = 6'b1_00_1_0_0;
    localparam logic [5:0] L_STALL = 6'b0_00_0_0_1;
    localparam logic [5:0] L_BR    = 6'b0_00_1_1_0;
    localparam logic [5:0] L_TAKEN = 6'b1_10_1_1_0;
    localparam logic [5:0] L_JUMP  = 6'b1_01_1_1_0;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset0", 1, L_RST);
        cycle("reset1", 1, L_RST);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("idle", 1, L_IDLE);

        drive(0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 0);   // lw r1 / add r3,r1,r2
        cycle("lw_use", 1, L_STALL);
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle("lw_after", 1, L_IDLE);
        drive(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);   // load to r0
        cycle("lw_r0", 1, L_IDLE);

        drive(0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0);   // store data reg hit
        cycle("sw_hit", 1, L_STALL);
        drive(0, 0, 0, 4, 1, 0, 1, 0, 1, 1, 0);   // immediate op, Rt unused
        cycle("imm_nohit", 1, L_IDLE);
        drive(0, 0, 0, 1, 2, 1, 0, 0, 1, 1, 0);   // shift uses shamt
        cycle("shamt_nohit", 1, L_IDLE);

        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("br_id", 1, L_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("br_taken", 1, L_TAKEN);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("br_id2", 1, L_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("br_nt", 1, L_IDLE);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("jump", 1, L_JUMP);

        drive(0, 1, 1, 1, 2, 0, 0, 0, 1, 1, 0);   // stall wins over branch and jump
        cycle("prio_stall", 1, L_STALL);
        drive(0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle("prio_br", 1, L_BR);
        drive(0, 1, 0, 1, 2, 0, 0, 0, 1, 1, 1);   // taken beats jump; ID nop ignored
        cycle("prio_taken", 1, L_TAKEN);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset2", 1, L_RST);
        drive(0, 0, 0, 3, 0, 0, 0, 0, 1, 3, 0);
        for (int i = 0; i < 3; i++) cycle("cnt_stall", 1, L_STALL);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("cnt_br", 1, L_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("cnt_nt", 1, L_IDLE);
`ifdef HAZARD_STALL_COUNT_EN
        checkVal("cnt_four", 32'(StallCount), 32'd4);
`endif
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rb_br", 1, L_BR);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // reset while branch in EX
        cycle("rb_reset", 1, L_RST);
`ifdef HAZARD_STALL_COUNT_EN
        checkVal("cnt_cleared", 32'(StallCount), 32'd0);
`endif
        drive(0, 0, 0, 2, 0, 0, 0, 0, 1, 2, 1);   // stall only possible in NO_HAZ
        cycle("rb_nohaz", 1, L_STALL);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            cycle("rand", 0, 6'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard/control-flow unit in the ID stage, next to the forwarding unit.
- Detects load-use hazards the forwarding unit cannot cover: a load in EX whose Rw is a source of the instruction in ID.
- Sequences the control-flow penalty for jumps (decoded in IF) and branches (resolved in EX).
- Drives PC write enable, next-PC select, IF/ID write/flush and the ID/EX bubble mux, so EX never consumes stale operands.

Parameters:
- REG_W, 5, width of register specifiers.
- CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IF_Jump  in  1  instruction in IF is j/jal.
- ID_Branch  in  1  instruction in ID is beq/bne.
- ID_Rs  in  REG_W  ID source register A.
- ID_Rt  in  REG_W  ID source register B.
- ID_UseShamt  in  1  ID instruction uses shamt, not Rs.
- ID_UseImmed  in  1  ID instruction uses immediate, not Rt.
- ID_MemWrite  in  1  ID instruction is a store (Rt always read).
- EX_MemRead  in  1  EX instruction is a load.
- EX_Rw  in  REG_W  EX destination register.
- EX_BranchTaken  in  1  branch in EX resolved taken (valid only in BRANCH_EX).
- PC_Write  out  1  PC register load enable.
- AddrSel  out  2  next-PC select: 00 PC+4, 01 jump target, 10 branch target.
- IF_Write  out  1  IF/ID register load enable.
- IF_Flush  out  1  IF/ID loads a nop (overrides IF_Write).
- Bubble  out  1  ID/EX control fields forced to zero (nop).
- StallCount  out  CNT_W  stall cycles since reset (only with HAZARD_STALL_COUNT_EN).

Behaviour:
- Outputs are combinational from state and current inputs (Mealy). State is a 1-bit FSM: NO_HAZ, BRANCH_EX.
- Reset=1 at an edge: state <= NO_HAZ.
- While Reset=1, outputs are forced to: PC_Write=1, AddrSel=00, IF_Write=1, IF_Flush=1, Bubble=1.
- LoadHaz = EX_MemRead & (EX_Rw!=0) & ((EX_Rw==ID_Rs & !ID_UseShamt) | (EX_Rw==ID_Rt & (!ID_UseImmed | ID_MemWrite))).
- Default outputs (no condition below applies): PC_Write=1, AddrSel=00, IF_Write=1, IF_Flush=0, Bubble=0.
- NO_HAZ, priority LoadHaz > ID_Branch > IF_Jump:
  - LoadHaz: PC_Write=0, IF_Write=0, Bubble=1; stay. Exactly 1 stall cycle; the next cycle the load is in MEM and the forwarding unit covers it.
  - ID_Branch: PC_Write=0, IF_Flush=1, Bubble=0 (the branch enters EX); next=BRANCH_EX.
  - IF_Jump: PC_Write=1, AddrSel=01, IF_Flush=1; stay. Penalty is 1 cycle.
  - A jump coinciding with a stall or branch is discarded or held by the PC hold. It is re-evaluated when refetched.
- BRANCH_EX (ID holds a nop, so LoadHaz/ID_Branch are ignored):
  - Taken: PC_Write=1, AddrSel=10, IF_Flush=1; IF_Jump is ignored. Total penalty is 2 cycles.
  - Not taken with IF_Jump=1: behave as the NO_HAZ jump case.
  - Not taken with IF_Jump=0: defaults (PC still holds branch+4).
  - Always next=NO_HAZ.
- Reset mid-branch: the pending branch is abandoned, and state returns to NO_HAZ on the same edge.

Optional Feature:
- HAZARD_STALL_COUNT_EN defined:
  - StallCount increments by 1 on each edge where Reset=0 and PC_Write=0. It wraps at 2^CNT_W-1 to 0.
  - StallCount is cleared to 0 on reset.
- Undefined: StallCount port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/header holds:
  - AddrSel encodings (ADDR_PC4=2'b00, ADDR_JUMP=2'b01, ADDR_BRANCH=2'b10).
  - State encodings (NO_HAZ=1'b0, BRANCH_EX=1'b1).
  - REG_W default, shared with the forwarding unit.
- One natural sub-module, load_use_detect: purely combinational LoadHaz comparator. Everything else stays in hazard_unit.

Test Plan:
- Reset=1 for 2 cycles -> PC_Write=1, IF_Flush=1, Bubble=1, AddrSel=00; after release with no inputs asserted: 1,0,0,00 and IF_Write=1.
- lw R1 in EX (EX_MemRead=1, EX_Rw=1), ID add R3,R1,R2 (Rs=1, Rt=2) -> one cycle PC_Write=0, IF_Write=0, Bubble=1. Repeat with EX_Rw=0 -> no stall.
- Store Rs=4, Rt=1, UseImmed=1, MemWrite=1, load EX_Rw=1 -> stall. Same with MemWrite=0 -> no stall. UseShamt=1, Rs=1 -> no stall.
- ID_Branch=1 -> cycle 1: PC_Write=0, IF_Flush=1. Cycle 2 (BRANCH_EX):
  - EX_BranchTaken=1 -> AddrSel=10, IF_Flush=1.
  - Rerun with EX_BranchTaken=0 -> AddrSel=00, IF_Flush=0.
- Simultaneous LoadHaz, ID_Branch and IF_Jump -> load stall only. Next cycle branch sequence begins. Jump in BRANCH_EX with taken=1 -> AddrSel=10.
- HAZARD_STALL_COUNT_EN build: 3 load stalls + 1 branch -> StallCount=4. Reset asserted in BRANCH_EX -> state NO_HAZ, StallCount=0.
